// File: rtl/io_mmio_wait_bridge.sv
`default_nettype none
// ============================================================================
// Module   : io_mmio_wait_bridge
// Purpose  : Bridge from the MCS I/O bus to the MMIO bus with slave wait
//            states. Each I/O request is registered and held on the MMIO bus
//            until the slave acknowledges. If no ack arrives within
//            TIMEOUT_CYCLES, the access is aborted with an error response.
//            Out-of-window and malformed requests are rejected without any
//            MMIO activity. Every error sets a sticky flag.
// Revision : 2.0 - wait-state capable replacement of the single-cycle bridge
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   io_addr_strobe          MCS transaction start
//   io_read/write_strobe    request direction (exactly one must be set)
//   io_byte_enable          write byte lanes
//   io_address              byte address
//   io_write_data           write data
//   io_read_data            response data (meaningful while io_ready on a read)
//   io_ready                one-cycle completion pulse
//   mmio_cs/read/write      MMIO access strobe and qualifiers, held while waiting
//   mmio_addr               word address io_address[ADDR_W+1:2]
//   mmio_byte_enable        byte lanes (all lanes on reads)
//   mmio_write_data         registered write data
//   mmio_read_data          slave read data, sampled with mmio_ack
//   mmio_ack                single-cycle slave completion
//   err_clear               clears err_flag
//   err_flag                sticky error indicator
// ============================================================================
module io_mmio_wait_bridge #(
    parameter logic [31:0] IO_BRIDGE_BASE = 32'hc000_0000,
    parameter int          ADDR_W         = 21,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hdead_beef
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_addr_strobe,
    input  logic              io_read_strobe,
    input  logic              io_write_strobe,
    input  logic [3:0]        io_byte_enable,
    input  logic [31:0]       io_address,
    input  logic [31:0]       io_write_data,
    output logic [31:0]       io_read_data,
    output logic              io_ready,
    output logic              mmio_cs,
    output logic              mmio_write,
    output logic              mmio_read,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [3:0]        mmio_byte_enable,
    output logic [31:0]       mmio_write_data,
    input  logic [31:0]       mmio_read_data,
    input  logic              mmio_ack,
    input  logic              err_clear,
    output logic              err_flag
);

    // Counter holds values 0..TIMEOUT_CYCLES-1 only; it never wraps because
    // the FSM leaves ACCESS when it reaches the last value.
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]        state_q,       state_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [31:0]       rdata_q,       rdata_d;
    logic              ready_q,       ready_d;
    logic              cs_q,          cs_d;
    logic              wr_q,          wr_d;
    logic              rd_q,          rd_d;
    logic [ADDR_W-1:0] addr_q,        addr_d;
    logic [3:0]        be_q,          be_d;
    logic [31:0]       wdata_q,       wdata_d;
    logic              err_q,         err_d;

    logic w_req;
    logic w_malformed;
    logic w_in_window;
    logic w_err_set;

    // A request needs at least one direction strobe; both together is malformed.
    assign w_req       = io_addr_strobe & (io_read_strobe | io_write_strobe);
    assign w_malformed = io_read_strobe & io_write_strobe;
    assign w_in_window = (io_address[31:24] == IO_BRIDGE_BASE[31:24]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        cs_d      = cs_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        w_err_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (!w_malformed && w_in_window) begin
                        state_d = ST_ACCESS;
                        cnt_d   = '0;
                        cs_d    = 1'b1;
                        rd_d    = io_read_strobe;
                        wr_d    = io_write_strobe;
                        addr_d  = io_address[ADDR_W+1:2];
                        be_d    = io_read_strobe ? 4'hf : io_byte_enable;
                        wdata_d = io_write_data;
                    end else begin
                        state_d   = ST_RESP;
                        ready_d   = 1'b1;
                        rdata_d   = ERR_DATA;
                        w_err_set = 1'b1;
                    end
                end
            end

            ST_ACCESS: begin
                // Ack has priority over a timeout reached in the same cycle.
                if (mmio_ack) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    cs_d    = 1'b0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) begin
                        rdata_d = mmio_read_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    ready_d   = 1'b1;
                    cs_d      = 1'b0;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    rdata_d   = ERR_DATA;
                    w_err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Setting takes precedence over a simultaneous clear.
        if (w_err_set) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'h0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign io_read_data     = rdata_q;
    assign io_ready         = ready_q;
    assign mmio_cs          = cs_q;
    assign mmio_write       = wr_q;
    assign mmio_read        = rd_q;
    assign mmio_addr        = addr_q;
    assign mmio_byte_enable = be_q;
    assign mmio_write_data  = wdata_q;
    assign err_flag         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_io_mmio_wait_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_mmio_wait_bridge
// Purpose  : Self-checking bench for io_mmio_wait_bridge. Expected responses
//            are queued when a request is issued and compared when io_ready
//            pulses; MMIO-side signals are checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_io_mmio_wait_bridge;

    localparam int          TO     = 8;
    localparam int          AW     = 21;
    localparam logic [31:0] DEAD   = 32'hdead_beef;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        bit          err;
        int          lat;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          io_addr_strobe;
    logic          io_read_strobe;
    logic          io_write_strobe;
    logic [3:0]    io_byte_enable;
    logic [31:0]   io_address;
    logic [31:0]   io_write_data;
    logic [31:0]   io_read_data;
    logic          io_ready;
    logic          mmio_cs;
    logic          mmio_write;
    logic          mmio_read;
    logic [AW-1:0] mmio_addr;
    logic [3:0]    mmio_byte_enable;
    logic [31:0]   mmio_write_data;
    logic [31:0]   mmio_read_data;
    logic          mmio_ack;
    logic          err_clear;
    logic          err_flag;

    int   n_pass;
    int   n_total;
    exp_t sb[$];

    io_mmio_wait_bridge #(
        .IO_BRIDGE_BASE (32'hc000_0000),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (DEAD)
    ) u_dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .io_addr_strobe   (io_addr_strobe),
        .io_read_strobe   (io_read_strobe),
        .io_write_strobe  (io_write_strobe),
        .io_byte_enable   (io_byte_enable),
        .io_address       (io_address),
        .io_write_data    (io_write_data),
        .io_read_data     (io_read_data),
        .io_ready         (io_ready),
        .mmio_cs          (mmio_cs),
        .mmio_write       (mmio_write),
        .mmio_read        (mmio_read),
        .mmio_addr        (mmio_addr),
        .mmio_byte_enable (mmio_byte_enable),
        .mmio_write_data  (mmio_write_data),
        .mmio_read_data   (mmio_read_data),
        .mmio_ack         (mmio_ack),
        .err_clear        (err_clear),
        .err_flag         (err_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Issue one request (strobe during cycle 0) and follow it to io_ready.
    // ack_wait < 0 means the slave never acknowledges.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int ack_wait, input logic [31:0] slave_data,
                           input bit clr0);
        bit          ok;
        bit          acked;
        int          alen;
        bit          done;
        exp_t        e;
        exp_t        got;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;

        ok       = (rd ^ wr) && (addr[31:24] == 8'hc0);
        acked    = ok && (ack_wait >= 0) && (ack_wait < TO);
        alen     = !ok ? 0 : (acked ? ack_wait + 1 : TO);
        exp_addr = {11'd0, addr[22:2]};
        exp_be   = rd ? 4'hf : be;

        e.lat      = ok ? alen + 1 : 1;
        e.err      = !acked;
        e.chk_data = rd;
        e.data     = acked ? slave_data : DEAD;

        @(negedge clk);
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_address      = addr;
        io_write_data   = wdata;
        io_byte_enable  = be;
        err_clear       = clr0;
        sb.push_back(e);

        @(negedge clk);
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_address      = $urandom;
        io_write_data   = $urandom;
        io_byte_enable  = 4'($urandom);
        err_clear       = 1'b0;

        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (io_ready) begin
                got = sb.pop_front();
                check("latency", 32'(c), 32'(got.lat));
                if (got.chk_data) check("rdata", io_read_data, got.data);
                check("err_flag", {31'd0, err_flag}, {31'd0, got.err});
                done = 1'b1;
            end else begin
                check("mmio_cs", {31'd0, mmio_cs}, {31'd0, c <= alen});
                if (c <= alen) begin
                    check("mmio_addr", {11'd0, mmio_addr}, exp_addr);
                    check("mmio_be", {28'd0, mmio_byte_enable}, {28'd0, exp_be});
                    check("mmio_rw", {30'd0, mmio_read, mmio_write}, {30'd0, rd, wr});
                    if (wr) check("mmio_wdata", mmio_write_data, wdata);
                end
                if (acked && c == alen) begin
                    mmio_ack       = 1'b1;
                    mmio_read_data = slave_data;
                end
                @(negedge clk);
                mmio_ack       = 1'b0;
                mmio_read_data = $urandom;
            end
        end
        if (!done) begin
            check("ready_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            @(negedge clk);
            check("ready_pulse", {31'd0, io_ready}, 32'd0);
            check("cs_after", {31'd0, mmio_cs}, 32'd0);
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_cleared", {31'd0, err_flag}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"},
              {26'd0, io_ready, mmio_cs, mmio_read, mmio_write, err_flag, |mmio_byte_enable},
              32'd0);
        check({tag, "_addr"}, {11'd0, mmio_addr}, 32'd0);
        check({tag, "_wdata"}, mmio_write_data, 32'd0);
        check({tag, "_rdata"}, io_read_data, 32'd0);
    endtask

    initial begin
        bit seen;
        n_pass          = 0;
        n_total         = 0;
        reset_n         = 1'b0;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_byte_enable  = 4'h0;
        io_address      = 32'h0;
        io_write_data   = 32'h0;
        mmio_read_data  = 32'h0;
        mmio_ack        = 1'b0;
        err_clear       = 1'b0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Minimum-latency read
        run_txn(1, 0, 32'hc000_0010, 32'h0, 4'h0, 0, 32'h1234_5678, 0);
        // Write with 5 wait states
        run_txn(0, 1, 32'hc000_0008, 32'haabb_ccdd, 4'b0011, 5, 32'h0, 0);
        // Highest word address in the window
        run_txn(0, 1, 32'hc07f_fffc, 32'h5a5a_0001, 4'b1000, 1, 32'h0, 0);
        // Read with no ack: timeout abort, flag sticky until cleared
        run_txn(1, 0, 32'hc000_0020, 32'h0, 4'h0, -1, 32'h0, 0);
        repeat (3) @(negedge clk);
        check("err_sticky", {31'd0, err_flag}, 32'd1);
        clear_err();
        // Out of window, with err_clear raised on the setting edge: set wins
        run_txn(1, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0, 1);
        clear_err();
        // Both direction strobes: error, no MMIO access
        run_txn(1, 1, 32'hc000_0040, 32'h1, 4'hf, 0, 32'h0, 0);
        clear_err();
        // Ack on the same cycle the timeout is reached: normal completion
        run_txn(1, 0, 32'hc000_0044, 32'h0, 4'h0, TO - 1, 32'hcafe_f00d, 0);

        // Address strobe with no direction: ignored
        @(negedge clk);
        io_addr_strobe = 1'b1;
        io_address     = 32'hc000_0050;
        @(negedge clk);
        io_addr_strobe = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (io_ready || mmio_cs) seen = 1'b1;
            @(negedge clk);
        end
        check("ignored_req", {31'd0, seen}, 32'd0);

        // Reset asserted in the middle of an access
        @(negedge clk);
        io_addr_strobe = 1'b1;
        io_read_strobe = 1'b1;
        io_address     = 32'hc000_0060;
        @(negedge clk);
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
        @(negedge clk);
        check("pre_reset_cs", {31'd0, mmio_cs}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (io_ready || mmio_cs) seen = 1'b1;
            @(negedge clk);
        end
        check("no_ready_after_reset", {31'd0, seen}, 32'd0);
        run_txn(1, 0, 32'hc000_0064, 32'h0, 4'h0, 2, 32'h0bad_cafe, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
